gh_rr_arbiter_8: RTL
====================

# gh_rr_arbiter_8

Eight-way round-robin arbiter that shares one UART-core resource (register port, TX buffer write path, or similar) between up to eight requesters. A registered 3-bit grant index feeds a `gh_decode_3to8` instance, which produces the one-hot grant vector. The grant holder keeps ownership until it drops its request, or until a programmable hold limit expires while other requesters are waiting. All outputs are registered or decoded from registers, so they are glitch-free toward the shared datapath.

## Interface
- `MAX_HOLD`, default 16: maximum consecutive cycles a holder keeps the grant while others wait; 0 means unlimited.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous and active-high.
- `en`  in  1  arbitration enable; when 0, no new grant is issued and an existing grant runs until release.
- `req`  in  8  request vector; bit i is requester i, level-sensitive.
- `gnt`  out  8  one-hot grant from the decoder; all zero when no grant is held.
- `gnt_id`  out  3  index of the current or most recent holder.
- `gnt_valid`  out  1  a grant is held; drives the decoder's g1 input, with g2n and g3n tied to 0.
- `busy`  out  1  equals `gnt_valid` OR any bit of `req`.

## Operation
- **Registers**
  - `state` ∈ {IDLE, GRANT}.
  - `gnt_id[2:0]`.
  - `ptr[2:0]`: the highest-priority index for the next search.
  - `hold_cnt`: width `$clog2(MAX_HOLD+1)`, minimum 1.
- **Winner search.** Scan `ptr`, `ptr+1`, … `ptr+7` modulo 8. The first asserted `req` bit wins.
- **IDLE**
  - If `en` and `req != 0`: go to GRANT, set `gnt_id` to the winner and `ptr` to winner+1 (mod 8), clear `hold_cnt`.
  - Otherwise stay in IDLE.
- **GRANT**
  - *Release.* Triggered when `req[gnt_id]` is 0.
    - If `en` and another request is pending: grant it directly (search from `ptr`, which excludes the old holder until wrap) and stay in GRANT. There is no idle bubble.
    - Otherwise return to IDLE.
  - *Timeout.* Triggered when `MAX_HOLD != 0`, `hold_cnt == MAX_HOLD-1`, and `req` has another bit set besides `gnt_id`.
    - Force rotation to the winner among the others.
    - If `en` is 0 at that moment, the rotation is withheld and the holder keeps the grant.
  - *Hold.* In all other cases keep the grant. `hold_cnt` increments and saturates at `MAX_HOLD-1`.
    - If no other requester is waiting, `hold_cnt` holds at saturation and the holder is not evicted.
- **Grant change.** Every grant change updates `gnt_id`, sets `ptr` = new winner+1 (mod 8), and clears `hold_cnt`.
- **Outputs.** `gnt` = decode(`gnt_id`) gated by `gnt_valid`; `gnt_valid` = (`state` == GRANT).
- **Glitches.** A `req` glitch of one cycle still yields a grant of at least one cycle. The requester must tolerate this.

## Timing
- **Reset values:** `state`=IDLE, `gnt_id`=0, `ptr`=0, `hold_cnt`=0, `gnt_valid`=0, `gnt`=8'h00, `busy`=0 (while `req`=0).
- **Request to grant:** `req` sampled at edge N gives `gnt` valid after edge N, i.e. 1-cycle latency.
- **Release to handoff:** holder drops `req` before edge N; the next holder's `gnt` is valid after edge N. The old `gnt` bit and the new `gnt` bit are never asserted in the same cycle.
- **Timeout:** with `MAX_HOLD`=M, the holder owns at most M consecutive cycles while others wait.
- **Pointer wrap:** a holder at index 7 rotates to search start 0.
- **Reset mid-grant:** `gnt` drops to 0 immediately (asynchronous). After `rst` deasserts, arbitration restarts from index 0.
- **Disable during IDLE:** `en` going 0 while in IDLE blocks the grant; `busy` still reflects `req`.

## Structure
- **Package `gh_arb_pkg`:**
  - `typedef enum logic {IDLE, GRANT} arb_state_t`
  - `localparam NUM_REQ = 8`
  - `localparam ID_W = 3`
  - function `rr_pick(req, ptr)` returning {found, idx}
- **Sub-module:** one instance of `gh_decode_3to8` (a=`gnt_id`, g1=`gnt_valid`, g2n=0, g3n=0). No other sub-modules.

## Test plan
- **Reset then single request:** `req`=8'h20 → after 1 edge `gnt`=8'h20, `gnt_id`=5. Drop `req` → next edge `gnt`=8'h00.
- **Full contention from reset:** `req`=8'hFF held, each holder drops `req` after 1 cycle of grant and reasserts it → grant order 0,1,2,…,7,0 with no idle cycles.
- **Timeout (`MAX_HOLD`=4):** `req`=8'h03, requester 0 never releases → `gnt`=8'h01 for exactly 4 cycles, then 8'h02.
- **Timeout with no competitor:** `req`=8'h01 held for 20 cycles → `gnt` stays 8'h01 throughout.
- **Enable gating:** `en`=0 with `req`=8'h10 → `gnt`=0 and `busy`=1. Raise `en` → grant to 4 after 1 edge. Lower `en` mid-grant → grant persists until `req[4]` drops, then IDLE.
- **Async reset mid-grant:** `gnt`=8'h40, assert `rst` mid-cycle → `gnt`=8'h00 without waiting for a clock edge. After release with `req`=8'h41 → grant goes to 0 first (`ptr` reset).

Source files
------------

// File: rtl/gh_arb_pkg.sv
// Shared types and the round-robin search helper for the 8-way arbiter.
package gh_arb_pkg;

   localparam int unsigned NUM_REQ = 8;
   localparam int unsigned ID_W    = 3;

   typedef enum logic {IDLE, GRANT} arb_state_t;

   typedef struct packed {
      logic            found;
      logic [ID_W-1:0] idx;
   } rr_pick_t;

   // First set bit of req, scanning ptr, ptr+1, ... modulo NUM_REQ.
   function automatic rr_pick_t rr_pick(input logic [NUM_REQ-1:0] req,
                                        input logic [ID_W-1:0]    ptr);
      rr_pick_t        res;
      logic [ID_W-1:0] pos;
      res = '0;
      // Walk from the far end so the nearest candidate is written last.
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         pos = ptr + ID_W'(k);
         if (req[pos]) begin
            res.found = 1'b1;
            res.idx   = pos;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/gh_decode_3to8.sv
// 3-to-8 decoder with one active-high and two active-low enables; active-high outputs.
module gh_decode_3to8 (
   input  logic [2:0] i_a,
   input  logic       i_g1,
   input  logic       i_g2n,
   input  logic       i_g3n,
   output logic [7:0] o_y
);

   always_comb begin
      o_y = '0;
      if (i_g1 && !i_g2n && !i_g3n) begin
         o_y[i_a] = 1'b1;
      end
   end

endmodule

// File: rtl/gh_rr_arbiter_8.sv
// Eight-way round-robin arbiter with release handoff and a programmable hold limit.
module gh_rr_arbiter_8
   import gh_arb_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 16
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_en,
   input  logic [NUM_REQ-1:0] i_req,
   output logic [NUM_REQ-1:0] o_gnt,
   output logic [ID_W-1:0]    o_gnt_id,
   output logic               o_gnt_valid,
   output logic               o_busy
);

   localparam int unsigned HCW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
   localparam logic [HCW-1:0] HOLD_SAT = (MAX_HOLD == 0) ? '0 : HCW'(MAX_HOLD - 1);

   arb_state_t         r_state, w_state;
   logic [ID_W-1:0]    r_gnt_id, w_gnt_id;
   logic [ID_W-1:0]    r_ptr, w_ptr;
   logic [HCW-1:0]     r_hold_cnt, w_hold_cnt;

   logic [NUM_REQ-1:0] w_others;
   rr_pick_t           w_pick_all, w_pick_oth;
   logic               w_timeout;
   logic               w_do_grant;
   logic [ID_W-1:0]    w_win;

   assign w_others   = i_req & ~(NUM_REQ'(1) << r_gnt_id);
   assign w_pick_all = rr_pick(i_req, r_ptr);
   assign w_pick_oth = rr_pick(w_others, r_ptr);
   assign w_timeout  = (MAX_HOLD != 0) && (r_hold_cnt == HOLD_SAT) && (|w_others);

   always_comb begin
      w_state    = r_state;
      w_gnt_id   = r_gnt_id;
      w_ptr      = r_ptr;
      w_hold_cnt = r_hold_cnt;
      w_do_grant = 1'b0;
      w_win      = r_gnt_id;
      unique case (r_state)
         IDLE: begin
            if (i_en && w_pick_all.found) begin
               w_do_grant = 1'b1;
               w_win      = w_pick_all.idx;
            end
         end
         GRANT: begin
            if (!i_req[r_gnt_id]) begin
               // Holder's bit is already clear, so the full search only sees others.
               if (i_en && w_pick_all.found) begin
                  w_do_grant = 1'b1;
                  w_win      = w_pick_all.idx;
               end else begin
                  w_state = IDLE;
               end
            end else if (w_timeout && i_en) begin
               w_do_grant = 1'b1;
               w_win      = w_pick_oth.idx;
            end else if (r_hold_cnt != HOLD_SAT) begin
               w_hold_cnt = r_hold_cnt + HCW'(1);
            end
         end
         default: w_state = IDLE;
      endcase
      if (w_do_grant) begin
         w_state    = GRANT;
         w_gnt_id   = w_win;
         w_ptr      = w_win + ID_W'(1);
         w_hold_cnt = '0;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state    <= IDLE;
         r_gnt_id   <= '0;
         r_ptr      <= '0;
         r_hold_cnt <= '0;
      end else begin
         r_state    <= w_state;
         r_gnt_id   <= w_gnt_id;
         r_ptr      <= w_ptr;
         r_hold_cnt <= w_hold_cnt;
      end
   end

   assign o_gnt_valid = (r_state == GRANT);
   assign o_gnt_id    = r_gnt_id;
   assign o_busy      = o_gnt_valid | (|i_req);

   gh_decode_3to8 u_decode (
      .i_a   (r_gnt_id),
      .i_g1  (o_gnt_valid),
      .i_g2n (1'b0),
      .i_g3n (1'b0),
      .o_y   (o_gnt)
   );

endmodule
